// File: rtl/y_window.sv
// Vertical 5-tap symmetric smoothing over four line buffers, three-stage pipeline.
// Optional build macro Y_WINDOW_ROUND_EN selects round-half-up instead of truncation.
module y_window #(
    parameter int unsigned h0         = 6,
    parameter int unsigned h1         = 58,
    parameter int unsigned h2         = 128,
    parameter int unsigned LINE_WIDTH = 640,
    parameter int unsigned COL_W      = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       validin,
    input  logic       sof,
    output logic [7:0] dout,
    output logic       validout
);

    logic [7:0] line1 [LINE_WIDTH];
    logic [7:0] line2 [LINE_WIDTH];
    logic [7:0] line3 [LINE_WIDTH];
    logic [7:0] line4 [LINE_WIDTH];

    logic [COL_W-1:0] col;
    logic [COL_W-1:0] col_eff;
    logic [2:0]       row;
    logic [2:0]       row_eff;
    logic             tag;

    logic [7:0] t1, t2, t3, t4;

    logic [7:0]  s1_t0, s1_t1, s1_t2, s1_t3, s1_t4;
    logic        s1_tag;
    logic [15:0] s2_p0, s2_p1, s2_p2;
    logic        s2_tag;

    logic [15:0] pair0, pair1, prod0, prod1, prod2, sum;

    // sof forces the current beat to row 0, column 0
    always_comb begin
        col_eff = sof ? '0 : col;
        row_eff = sof ? 3'd0 : row;
        tag     = (row_eff >= 3'd4);
        t1      = line1[col_eff];
        t2      = line2[col_eff];
        t3      = line3[col_eff];
        t4      = line4[col_eff];
    end

    // Non-blocking writes give read-before-write on a shared address
    always_ff @(posedge clock) begin
        if (validin) begin
            line1[col_eff] <= din;
            line2[col_eff] <= t1;
            line3[col_eff] <= t2;
            line4[col_eff] <= t3;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            col <= '0;
            row <= 3'd0;
        end else if (validin) begin
            if (col_eff == COL_W'(LINE_WIDTH - 1)) begin
                col <= '0;
                row <= (row_eff == 3'd4) ? 3'd4 : row_eff + 3'd1;
            end else begin
                col <= col_eff + 1'b1;
                row <= row_eff;
            end
        end
    end

    always_comb begin
        pair0 = {8'd0, s1_t0} + {8'd0, s1_t4};
        pair1 = {8'd0, s1_t1} + {8'd0, s1_t3};
        prod0 = 16'(h0) * pair0;
        prod1 = 16'(h1) * pair1;
        prod2 = 16'(h2) * {8'd0, s1_t2};
`ifdef Y_WINDOW_ROUND_EN
        sum   = s2_p0 + s2_p1 + s2_p2 + 16'd128;
`else
        sum   = s2_p0 + s2_p1 + s2_p2;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_t0    <= 8'd0;
            s1_t1    <= 8'd0;
            s1_t2    <= 8'd0;
            s1_t3    <= 8'd0;
            s1_t4    <= 8'd0;
            s1_tag   <= 1'b0;
            s2_p0    <= 16'd0;
            s2_p1    <= 16'd0;
            s2_p2    <= 16'd0;
            s2_tag   <= 1'b0;
            dout     <= 8'd0;
            validout <= 1'b0;
        end else begin
            // The whole pipeline only moves on accepted beats
            validout <= validin & s2_tag;
            if (validin) begin
                s1_t0  <= din;
                s1_t1  <= t1;
                s1_t2  <= t2;
                s1_t3  <= t3;
                s1_t4  <= t4;
                s1_tag <= tag;
                s2_p0  <= prod0;
                s2_p1  <= prod1;
                s2_p2  <= prod2;
                s2_tag <= s1_tag;
                dout   <= sum[15:8];
            end
        end
    end

endmodule

// File: tb/tb_y_window.sv
// Directed bench for y_window: table of frame vectors plus sof/reset mid-frame sequences.
module tb_y_window;

    localparam int LW = 8;

`ifdef Y_WINDOW_ROUND_EN
    localparam int IMP0 = 128;
    localparam int IMP1 = 58;
    localparam int IMP2 = 6;
`else
    localparam int IMP0 = 127;
    localparam int IMP1 = 57;
    localparam int IMP2 = 5;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] din = 8'd0;
    logic       validin = 1'b0;
    logic       sof = 1'b0;
    logic [7:0] dout;
    logic       validout;

    y_window #(
        .LINE_WIDTH(LW),
        .COL_W     (3)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .din     (din),
        .validin (validin),
        .sof     (sof),
        .dout    (dout),
        .validout(validout)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int acc_cnt = 0;
    int stall_viol = 0;
    logic prev_acc = 1'b0;
    int out_d[$];
    int out_a[$];

    always @(posedge clock) begin
        if (validin && !reset) acc_cnt <= acc_cnt + 1;
        prev_acc <= validin && !reset;
    end

    always @(negedge clock) begin
        if (validout) begin
            out_d.push_back(int'(dout));
            out_a.push_back(acc_cnt);
            if (!prev_acc) stall_viol <= stall_viol + 1;
        end
    end

    typedef struct {
        string name;
        int    kind;     // 0 flat, 1 impulse at row 2 col 3
        int    gaps;     // idle cycles after each beat
        int    rows;
        int    pulses;
        int    first;    // accepted-beat count at first pulse
        int    bg;
        int    c0;
        int    c1;
        int    c2;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic s, input int gaps);
        din = d;
        sof = s;
        validin = 1'b1;
        @(posedge clock);
        #1;
        validin = 1'b0;
        sof = 1'b0;
        repeat (gaps) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic frame(input int kind, input int beats, input int gaps, input logic [7:0] val,
                         input int flush);
        for (int b = 0; b < beats; b++) begin
            logic [7:0] p;
            if (kind == 0) p = val;
            else p = (b / LW == 2 && b % LW == 3) ? 8'd255 : 8'd0;
            send(p, b == 0, gaps);
        end
        for (int f = 0; f < flush; f++) send(8'd0, 1'b0, gaps);
        repeat (4) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    vec_t vecs[4];

    initial begin
        vecs[0] = '{"flat", 0, 0, 6, 16, 35, 100, 100, 100, 100};
        vecs[1] = '{"flat_stall", 0, 2, 6, 16, 35, 100, 100, 100, 100};
        vecs[2] = '{"impulse", 1, 0, 7, 24, 35, 0, IMP0, IMP1, IMP2};
        vecs[3] = '{"impulse_stall", 1, 2, 7, 24, 35, 0, IMP0, IMP1, IMP2};

        // Reset state
        @(posedge clock);
        @(negedge clock);
        check("reset_dout", int'(dout), 0);
        check("reset_validout", int'(validout), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        foreach (vecs[i]) begin
            int qs, base, sv, n;
            do_reset();
            qs = out_d.size();
            base = acc_cnt;
            sv = stall_viol;
            frame(vecs[i].kind, vecs[i].rows * LW, vecs[i].gaps, 8'd100, 2);
            n = out_d.size() - qs;
            check({vecs[i].name, "_pulses"}, n, vecs[i].pulses);
            check({vecs[i].name, "_stall_viol"}, stall_viol - sv, 0);
            if (n > 0) check({vecs[i].name, "_first"}, out_a[qs] - base, vecs[i].first);
            for (int k = 0; k < n; k++) begin
                int exp;
                exp = (k == 3) ? vecs[i].c0 : (k == 11) ? vecs[i].c1 :
                      (k == 19) ? vecs[i].c2 : vecs[i].bg;
                check($sformatf("%s_dout%0d", vecs[i].name, k), out_d[qs + k], exp);
            end
        end

        // sof mid-frame at row 5 col 4, new frame of 50s
        begin
            int qs, base, n, first;
            do_reset();
            frame(0, 44, 0, 8'd100, 0);
            qs = out_d.size();
            base = acc_cnt;
            frame(0, 48, 0, 8'd50, 2);
            n = 0;
            first = -1;
            for (int k = qs; k < out_d.size(); k++) begin
                if (out_a[k] - base > 2) begin
                    if (first < 0) first = k;
                    n++;
                end
            end
            check("sof_mid_pulses", n, 16);
            if (first >= 0) begin
                check("sof_mid_first", out_a[first] - base, 35);
                check("sof_mid_dout", out_d[first], 50);
            end else begin
                check("sof_mid_first", -1, 35);
            end
        end

        // Reset at row 5, then a fresh frame of 70s
        begin
            int qs, base, n;
            do_reset();
            frame(0, 44, 0, 8'd100, 0);
            reset = 1'b1;
            @(posedge clock);
            @(negedge clock);
            check("rst_mid_dout", int'(dout), 0);
            check("rst_mid_validout", int'(validout), 0);
            @(posedge clock);
            #1;
            reset = 1'b0;
            qs = out_d.size();
            base = acc_cnt;
            frame(0, 48, 0, 8'd70, 2);
            n = out_d.size() - qs;
            check("rst_mid_pulses", n, 16);
            if (n > 0) begin
                check("rst_mid_first", out_a[qs] - base, 35);
                check("rst_mid_dout70", out_d[qs], 70);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/y_window.md
# y_window

Vertical 5-tap separable smoothing stage for the 5x5 window filter. It consumes the row-major, 8-bit, horizontally filtered pixel stream produced by the horizontal window stage and buffers the four previous lines in on-chip line memories. Each column is then filtered vertically with the symmetric kernel {h0,h1,h2,h1,h0}, and the fully 2-D-smoothed pixel goes to the feature-detection stages downstream.

## Interface
- h0, 6: outer tap weight (rows r and r-4).
- h1, 58: inner tap weight (rows r-1 and r-3).
- h2, 128: centre tap weight (row r-2). 2*h0+2*h1+h2 must equal 256.
- LINE_WIDTH, 640: pixels per line.
- COL_W, 10: column counter width; 2^COL_W >= LINE_WIDTH.
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- din  in  8  horizontally filtered pixel.
- validin  in  1  din valid this cycle (one accepted beat).
- sof  in  1  start of frame; qualified by validin; marks the beat as row 0, column 0.
- dout  out  8  vertically filtered pixel.
- validout  out  1  dout holds a new valid result this cycle.

## Operation
- **Line buffers:** four LINE_WIDTH x 8 memories L1..L4, all indexed by column counter col.
  - On an accepted beat at col: read L1[col]..L4[col] as taps t1..t4, with t0 = din.
  - Write L1[col]=din, L2[col]=old L1[col], L3[col]=old L2[col], L4[col]=old L3[col].
  - Memories are not reset.
- **Counters:** col (COL_W bits) and row (3 bits, saturating at 4).
  - Accepted beat: col wraps from LINE_WIDTH-1 to 0, and row increments on the wrap.
  - sof on an accepted beat: that beat is treated as col=0, row=0. Counters then continue from col=1.
  - sof mid-line or mid-frame: counters restart; buffer contents become stale but are masked by the row gating.
- **Arithmetic:** sum = h0*(t0+t4) + h1*(t1+t3) + h2*t2, 16 bits unsigned; maximum is 65280. dout = sum[15:8] (truncate).
- **Valid tag:** a beat is tagged valid iff row >= 4 at that beat (after any sof override). The result is centred on row-2 at the same column. No horizontal gating is applied.
- **Pipeline:** three register stages:
  - S1: taps and tag.
  - S2: pair sums and products.
  - S3: dout and tag.
  - All stages advance only on accepted beats.
- dout holds its value between results.

## Timing
- Reset values: dout=0, validout=0, col=0, row=0, all pipeline tags=0.
- **Latency:** the result of accepted beat k loads dout at the clock edge that accepts beat k+2. validout is high for exactly the following cycle, and only if beat k's tag was valid.
- **Stalls:** with validin low, the pipeline freezes and validout=0. Results still in flight emerge only when later beats arrive; at end of frame, the source supplies 2 flush beats.
- **Back-to-back** validin gives one validout per beat once the pipeline is primed.
- **Reset mid-operation:** all tags clear, so no stale validout is produced. The next frame must begin with sof. Line-buffer contents are ignored until 4 rows refill.
- Read and write to the same L address on the same beat must return the old data (read-before-write).

## Configuration
- Y_WINDOW_ROUND_EN defined: dout = (sum + 128)[15:8], i.e. round-half-up.
  - Maximum is 65408, so no overflow and no saturation logic is needed.
- Y_WINDOW_ROUND_EN undefined: truncation as above.
- Latency is identical in both builds.

## Test plan
- **Flat field:** LINE_WIDTH=8, sof then 6 rows of constant 100, continuous validin, plus 2 flush beats -> exactly 16 validout pulses, first one on the cycle after beat 34 (row 4, col 2) is accepted, each with dout=100. No validout during rows 0-3.
- **Impulse (truncating build):** 255 at row 2, col 3, else 0 -> centred outputs at column 3 are:
  - input row 4: dout=127.
  - row 5: 57.
  - row 6: 5.
  - All other outputs 0.
- **Impulse (Y_WINDOW_ROUND_EN build):** same stimulus -> 128, 58, 6.
- **Stall:** flat-field stimulus with validin toggling 1,0,0,1 -> identical dout sequence and pulse count. validout is never high on the cycle after a non-accepted beat.
- **sof mid-frame:** assert sof at row 5, col 4 -> validout stays low until 4 new rows are accepted, and the first post-sof result equals that of a fresh frame.
- **Reset mid-frame:** reset at row 5 -> dout=0 and validout=0 next cycle, and no validout until sof plus 4 rows plus 2 beats.
